// File: rtl/instr_composer.sv
// rtl/instr_composer.sv - packs R/I/J instruction fields into words and queues them with word addresses
// Optional opcode/format consistency checking: define INSTR_COMPOSER_CHECK_EN.
module instr_composer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       word_cnt,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0] packed_word;
    logic        pkt_ok;
    logic        handshake;
    logic        push;
    logic        pop;

    always_comb begin
        packed_word = 32'h0;
        pkt_ok      = 1'b1;
        case (fmt)
            FMT_R: begin
                packed_word = {opcode, rs, rt, rd, shamt, funct};
`ifdef INSTR_COMPOSER_CHECK_EN
                pkt_ok = (opcode == 6'd0);
`endif
            end
            FMT_I: begin
                packed_word = {opcode, rs, rt, imm16};
`ifdef INSTR_COMPOSER_CHECK_EN
                pkt_ok = (opcode != 6'd0) && (opcode != 6'd2) && (opcode != 6'd3);
`endif
            end
            FMT_J: begin
                packed_word = {opcode, target};
`ifdef INSTR_COMPOSER_CHECK_EN
                pkt_ok = (opcode == 6'd2) || (opcode == 6'd3);
`endif
            end
            default: pkt_ok = 1'b0;
        endcase
    end

    // in_ready comes from the registered count only, so a same-cycle pop never frees a slot
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;
    assign out_addr  = addr_q;

    assign handshake = in_valid && in_ready && !clear;
    assign push      = handshake && pkt_ok;
    assign pop       = out_valid && out_ready && !clear;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= packed_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_q   <= '0;
            word_cnt <= 16'h0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_q   <= base_addr;
            word_cnt <= 16'h0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + 1'b1;
                if (word_cnt != 16'hFFFF) begin
                    word_cnt <= word_cnt + 16'h1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // err survives clear; only rst removes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (handshake && !pkt_ok) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_composer.sv
// tb/tb_instr_composer.sv - scoreboard bench for instr_composer
module tb_instr_composer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_addr;
    logic [15:0] word_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [41:0] sbq[$];
    logic [9:0]  exp_addr;

    always #5 clk = ~clk;

    instr_composer #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .target(target), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .word_cnt(word_cnt), .err(err)
    );

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Starts just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                        input bit exp_push, input logic [31:0] exp_data);
        bit done = 0;
        fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = s; funct = fn;
        imm16 = im; target = tg; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (exp_push) begin
                    sbq.push_back({exp_addr, exp_data});
                    exp_addr = exp_addr + 10'd1;
                end
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 42'd0, 42'd1);
    endtask

    task automatic do_clear(input logic [9:0] b);
        clear = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sbq.delete();
        exp_addr = b;
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 42'(sbq.size()), 42'd0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; base_addr = 10'h0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = 2'b00; opcode = 6'h0; rs = 5'h0; rt = 5'h0; rd = 5'h0; shamt = 5'h0;
        funct = 6'h0; imm16 = 16'h0; target = 26'h0;
        exp_addr = 10'h0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && !clear && out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_word", {out_addr, out_data}, 42'd0);
                    end else begin
                        chk("word", {out_addr, out_data}, sbq.pop_front());
                    end
                end
            end
        join_none

        @(negedge clk);
        chk("rst_in_ready", 42'(in_ready), 42'd1);
        chk("rst_out_valid", 42'(out_valid), 42'd0);
        chk("rst_out_data", 42'(out_data), 42'd0);
        chk("rst_out_addr", 42'(out_addr), 42'd0);
        chk("rst_word_cnt", 42'(word_cnt), 42'd0);
        chk("rst_err", 42'(err), 42'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R packet, one-cycle latency
        out_ready = 1'b1;
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00221820);
        @(negedge clk);
        chk("lat_valid", 42'(out_valid), 42'd1);
        chk("lat_data", 42'(out_data), 42'h00221820);
        @(posedge clk);
        #1;
        chk("word_cnt_1", 42'(word_cnt), 42'd1);

        // I then J back-to-back
        do_clear(10'h0);
        chk("clear_word_cnt", 42'(word_cnt), 42'd0);
        send(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1, 32'h20220005);
        send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1, 32'h08000010);
        wait_empty();

        // Fill to full, fifth held until the consumer drains
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_clear(10'h0);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00000820);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00001020);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00001820);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00002020);
        @(negedge clk);
        chk("full_in_ready", 42'(in_ready), 42'd0);
        @(posedge clk);
        #1;
        fork
            send(2'b00, 6'd0, 5'd0, 5'd0, 5'd5, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00002820);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();
        @(posedge clk);
        #1;
        chk("word_cnt_5", 42'(word_cnt), 42'd5);

        // clear with queued words, then address wrap
        out_ready = 1'b0;
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00003020);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd7, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00003820);
        do_clear(10'h3FF);
        @(negedge clk);
        chk("clear_out_valid", 42'(out_valid), 42'd0);
        chk("clear_out_addr", 42'(out_addr), 42'h3FF);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00004020);
        send(2'b00, 6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h00004820);
        wait_empty();
        @(posedge clk);
        #1;
        chk("word_cnt_wrap", 42'(word_cnt), 42'd2);

        // Reserved format: dropped, sticky err
        send(2'b11, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 0, 32'h0);
        @(negedge clk);
        chk("fmt11_err", 42'(err), 42'd1);
        chk("fmt11_no_word", 42'(out_valid), 42'd0);
        @(posedge clk);
        #1;
        do_clear(10'h0);
        @(negedge clk);
        chk("err_after_clear", 42'(err), 42'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("err_after_rst", 42'(err), 42'd0);
        chk("rst_mid_in_ready", 42'(in_ready), 42'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        exp_addr = 10'h0;

        // R format with a non-zero opcode
`ifdef INSTR_COMPOSER_CHECK_EN
        send(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 0, 32'h0);
        @(negedge clk);
        chk("check_err", 42'(err), 42'd1);
        chk("check_dropped", 42'(out_valid), 42'd0);
`else
        send(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1, 32'h20221820);
        @(negedge clk);
        chk("nocheck_err", 42'(err), 42'd0);
`endif
        wait_empty();
        @(posedge clk);
        #1;
        chk("sb_empty", 42'(sbq.size()), 42'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_composer.md
# instr_composer

Packs decoded MIPS instruction fields (R, I or J format) back into 32-bit instruction words and streams them, each tagged with a sequential word address, toward instruction memory. It is the inverse of the datapath's field splitter and sits in the program-loader / test-infrastructure path that fills instruction memory before or alongside CPU execution. A small FIFO decouples field producers from the memory-write consumer.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 10: word-address width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties FIFO, loads address from base_addr.
- base_addr  in  ADDR_W  start word address, sampled on clear.
- in_valid  in  1  field packet valid.
- in_ready  out  1  packet accepted when in_valid && in_ready.
- fmt  in  2  00 = R, 01 = I, 10 = J, 11 = reserved.
- opcode  in  6; rs, rt, rd, shamt  in  5 each; funct  in  6; imm16  in  16; target  in  26.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes head when out_valid && out_ready.
- out_data  out  32  packed instruction at FIFO head.
- out_addr  out  ADDR_W  word address of head word.
- word_cnt  out  16  words popped since reset/clear; saturates at 0xFFFF.
- err  out  1  sticky; set by a rejected packet.

## Operation
- Packing:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm16}.
  - J: {opcode, target}.
  - Fields not used by the selected format are ignored.
- fmt = 11: handshake completes (in_ready honoured), nothing enqueued, err set.
- FIFO: circular, rd/wr pointers plus count register (0..DEPTH).
  - in_ready = (count < DEPTH), derived from registered count only. No push when full, even if a pop occurs in the same cycle.
  - out_valid = (count != 0).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged; both pointers advance.
- out_addr: address register, incremented by 1 on each pop; wraps modulo 2^ADDR_W (max → 0).
- clear: has priority over push and pop in the same cycle.
  - Pointers, count and word_cnt go to 0; address ← base_addr.
  - err is NOT cleared (rst only).
  - A packet offered in the same cycle as clear is dropped.
- out_data / out_addr are held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_addr = 0, word_cnt = 0, err = 0; FIFO empty.
- rst asserted mid-stream: all state returns to reset values immediately; queued words are lost.
- Latency: a packet accepted in cycle N appears on out_data with out_valid = 1 in cycle N+1 when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained while not full.
- err rises in the cycle after the offending handshake.

## Configuration
- INSTR_COMPOSER_CHECK_EN:
  - Defined: format/opcode consistency is enforced.
    - R requires opcode == 0.
    - J requires opcode ∈ {2, 3}.
    - I requires opcode ∉ {0, 2, 3}.
    - A violating packet is handshaken, dropped, and sets err.
  - Undefined: only fmt = 11 is rejected; all other packets are packed verbatim.

## Test plan
- Reset, then R packet (opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20) with out_ready = 1 → next cycle out_data = 0x00221820, out_addr = 0; word_cnt = 1 after the pop.
- I packet (opcode 0x08, rs 1, rt 2, imm16 0x0005), then J packet (opcode 2, target 0x0000010), back-to-back → 0x20220005 at addr 0, then 0x08000010 at addr 1.
- out_ready = 0, push 5 packets with DEPTH = 4 → in_ready drops after the 4th acceptance; the 5th is held by the producer; raising out_ready delivers the words in order at addrs 0–3, then the 5th at addr 4.
- clear with base_addr = 0x3FF while 2 words are queued → out_valid = 0 next cycle; the next pushes emerge at addrs 0x3FF, then 0x000 (wrap).
- fmt = 11 packet → nothing enqueued, err = 1 and remains 1 after clear; only rst clears it.
- With INSTR_COMPOSER_CHECK_EN: R packet with opcode 0x08 → dropped, err = 1. Without the macro, the same packet emits 0x20221820.
